// File: rtl/voice_pkg.sv
// Shared types and constants for the voice allocator and its synchroniser.
package voice_pkg;

    localparam int NUM_NOTES = 12;
    localparam int CNT_W_DEF = 16;

    typedef logic [3:0] note_idx_t;

    // Octave select is kept as a plain 3-bit vector so illegal encodings stay representable.
    typedef logic [2:0] octave_t;

    localparam octave_t OCT_LOW  = 3'b001;
    localparam octave_t OCT_MID  = 3'b010;
    localparam octave_t OCT_HIGH = 3'b100;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser with an extra history flop for rise/fall pulse detection.
module sync_edge #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic [W-1:0] din,
    output logic [W-1:0] level,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);

    logic [W-1:0] meta_r;
    logic [W-1:0] sync_r;
    logic [W-1:0] prev_r;

    // Synchroniser chain followed by one cycle of history for edge detection.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            meta_r <= '0;
            sync_r <= '0;
            prev_r <= '0;
        end else begin
            meta_r <= din;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign level = sync_r;
    assign rise  = sync_r & ~prev_r;
    assign fall  = ~sync_r & prev_r;

endmodule

// File: rtl/voice_allocator.sv
// Octave FSM, key pending mask, voice allocation/stealing and per-voice count routing.
module voice_allocator
    import voice_pkg::*;
#(
    parameter int NUM_VOICES = 4,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                        clk,
    input  logic                        nrst,
    input  logic [NUM_NOTES-1:0]        keys,
    input  logic                        octave_btn,
    input  logic [NUM_NOTES*CNT_W-1:0]  note_div,
    output logic [2:0]                  octave_sel,
    output logic [NUM_VOICES-1:0]       voice_en,
    output logic [4*NUM_VOICES-1:0]     voice_note,
    output logic [CNT_W*NUM_VOICES-1:0] voice_div
);

    localparam int PTR_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    // Count selected by a note index; indices 12..15 read as zero.
    function automatic logic [CNT_W-1:0] count_of(input logic [NUM_NOTES*CNT_W-1:0] divs,
                                                  input note_idx_t n);
        count_of = '0;
        for (int i = 0; i < NUM_NOTES; i++) begin
            if (n == note_idx_t'(i)) count_of = divs[i*CNT_W +: CNT_W];
        end
    endfunction

    // True when the note held by a voice sees a release edge this cycle.
    function automatic logic note_hit(input logic [NUM_NOTES-1:0] mask, input note_idx_t n);
        note_hit = 1'b0;
        for (int i = 0; i < NUM_NOTES; i++) begin
            if (n == note_idx_t'(i)) note_hit = mask[i];
        end
    endfunction

    logic [NUM_NOTES-1:0] key_level_s, key_rise_s, key_fall_s;
    logic [0:0]           btn_level_s, btn_rise_s, btn_fall_s;

    sync_edge #(.W(NUM_NOTES)) u_key_sync (
        .clk   (clk),
        .nrst  (nrst),
        .din   (keys),
        .level (key_level_s),
        .rise  (key_rise_s),
        .fall  (key_fall_s)
    );

    sync_edge #(.W(1)) u_btn_sync (
        .clk   (clk),
        .nrst  (nrst),
        .din   (octave_btn),
        .level (btn_level_s),
        .rise  (btn_rise_s),
        .fall  (btn_fall_s)
    );

    // ---------------- Octave FSM ----------------
    octave_t oct_state_r;
    octave_t oct_next_s;

    // Octave state register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) oct_state_r <= OCT_LOW;
        else       oct_state_r <= oct_next_s;
    end

    // Octave next state: advance on a button rise, recover illegal codes to LOW.
    always_comb begin
        oct_next_s = OCT_LOW;
        case (oct_state_r)
            OCT_LOW:  oct_next_s = btn_rise_s[0] ? OCT_MID  : OCT_LOW;
            OCT_MID:  oct_next_s = btn_rise_s[0] ? OCT_HIGH : OCT_MID;
            OCT_HIGH: oct_next_s = btn_rise_s[0] ? OCT_LOW  : OCT_HIGH;
            default:  oct_next_s = OCT_LOW;
        endcase
    end

    // Octave output is the one-hot state itself.
    always_comb begin
        octave_sel = oct_state_r;
    end

    // ---------------- Allocator ----------------
    logic [NUM_NOTES-1:0]  pending_r, pending_next_s, pend_eff_s;
    logic [PTR_W-1:0]      steal_ptr_r, steal_ptr_next_s;
    logic [NUM_VOICES-1:0] voice_en_r, voice_en_next_s, released_s, free_s;
    note_idx_t             voice_note_r [NUM_VOICES];
    note_idx_t             voice_note_next_s [NUM_VOICES];
    logic [CNT_W-1:0]      voice_div_r [NUM_VOICES];
    note_idx_t             cand_s;
    logic                  cand_vld_s;
    logic [PTR_W-1:0]      free_idx_s;
    logic                  free_vld_s;

    // Release handling, candidate/free-voice search and next voice state.
    always_comb begin
        pend_eff_s       = pending_r & ~key_fall_s;
        pending_next_s   = (pending_r | key_rise_s) & ~key_fall_s;
        steal_ptr_next_s = steal_ptr_r;
        cand_s           = 4'd0;
        cand_vld_s       = 1'b0;
        free_idx_s       = '0;
        free_vld_s       = 1'b0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            released_s[v]        = voice_en_r[v] & note_hit(key_fall_s, voice_note_r[v]);
            voice_note_next_s[v] = voice_note_r[v];
        end
        free_s          = ~voice_en_r | released_s;
        voice_en_next_s = voice_en_r & ~released_s;
        // Scan downwards so the lowest set index wins.
        for (int n = NUM_NOTES - 1; n >= 0; n--) begin
            if (pend_eff_s[n]) begin
                cand_s     = note_idx_t'(n);
                cand_vld_s = 1'b1;
            end else begin
                cand_vld_s = cand_vld_s;
            end
        end
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (free_s[v]) begin
                free_idx_s = PTR_W'(v);
                free_vld_s = 1'b1;
            end else begin
                free_vld_s = free_vld_s;
            end
        end
        if (cand_vld_s) begin
            pending_next_s[cand_s] = 1'b0;
            if (free_vld_s) begin
                voice_en_next_s[free_idx_s]   = 1'b1;
                voice_note_next_s[free_idx_s] = cand_s;
            end else begin
                // Every voice busy: overwrite the oldest-stolen slot in round-robin order.
                voice_note_next_s[steal_ptr_r] = cand_s;
                voice_en_next_s[steal_ptr_r]   = 1'b1;
                if (steal_ptr_r == PTR_W'(NUM_VOICES - 1)) steal_ptr_next_s = '0;
                else                                       steal_ptr_next_s = steal_ptr_r + 1'b1;
            end
        end else begin
            pending_next_s = pending_next_s;
        end
    end

    // Allocator state: pending mask, steal pointer and voice assignments.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pending_r   <= '0;
            steal_ptr_r <= '0;
            voice_en_r  <= '0;
            for (int v = 0; v < NUM_VOICES; v++) voice_note_r[v] <= 4'd0;
        end else begin
            pending_r   <= pending_next_s;
            steal_ptr_r <= steal_ptr_next_s;
            voice_en_r  <= voice_en_next_s;
            for (int v = 0; v < NUM_VOICES; v++) voice_note_r[v] <= voice_note_next_s[v];
        end
    end

    // Per-voice count routing, zero for idle voices.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int v = 0; v < NUM_VOICES; v++) voice_div_r[v] <= '0;
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (voice_en_r[v]) voice_div_r[v] <= count_of(note_div, voice_note_r[v]);
                else               voice_div_r[v] <= '0;
            end
        end
    end

    // Pack the per-voice registers onto the output buses.
    always_comb begin
        voice_en = voice_en_r;
        for (int v = 0; v < NUM_VOICES; v++) begin
            voice_note[4*v +: 4]         = voice_note_r[v];
            voice_div[CNT_W*v +: CNT_W]  = voice_div_r[v];
        end
    end

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
- Controller in front of the 12-note frequency divider.
- Tracks the octave button and drives the divider's one-hot octave select.
- Shares a small pool of oscillator voices among 12 key requesters.
- Routes the selected note's count from the divider to each active voice.

Parameters:
NUM_VOICES, 4, number of oscillator voices (1..8)
CNT_W, 16, width of a divider count

Ports:
clk  input  1  system clock, 10 MHz
nrst  input  1  asynchronous active-low reset
keys  input  12  raw key levels, bit i = note i (0=C .. 11=B), asynchronous
octave_btn  input  1  raw octave button, asynchronous, already debounced
note_div  input  12*CNT_W  packed divider counts, note i at [CNT_W*i+CNT_W-1 : CNT_W*i]
octave_sel  output  3  one-hot octave to divider: 001 low, 010 mid, 100 high
voice_en  output  NUM_VOICES  voice v active
voice_note  output  4*NUM_VOICES  note index per voice, packed like note_div
voice_div  output  CNT_W*NUM_VOICES  count per voice, packed

Behaviour:
- Reset (nrst low, asynchronous):
  - octave_sel=001; voice_en=0; voice_note=0; voice_div=0.
  - Pending mask, steal pointer and all synchronisers cleared.
  - Reset mid-operation aborts everything; no voice survives.
- Input sync: keys and octave_btn each pass through a 2-flop synchroniser.
  - Rising and falling edges are detected on the synchronised value, 1 cycle after it.
  - Raw-to-edge latency is 3 clk.
- Octave FSM (states LOW=001, MID=010, HIGH=100):
  - Each octave_btn rising edge advances LOW->MID->HIGH->LOW.
  - Any illegal encoding -> LOW on the next clk.
  - Buttons held high produce only one advance.
- Key press (synchronised rising edge on bit i): sets pending[i].
- Key release (falling edge on bit i):
  - Clears pending[i].
  - Any voice with voice_en=1 and voice_note=i gets voice_en=0 in the same cycle the edge is seen.
- Allocation, at most one per cycle:
  - Candidate is the lowest-index set pending bit.
  - Free mask = voices with voice_en=0, including voices freed by a release in that same cycle.
  - If a free voice exists: the lowest-index free voice v gets voice_note[v]=i and voice_en[v]=1 next clk; pending[i] clears.
  - If no voice is free: steal voice steal_ptr.
    - voice_note is overwritten and voice_en stays 1.
    - steal_ptr increments mod NUM_VOICES; it advances only on a steal.
    - The displaced key stays held but unassigned and is never re-requested.
- Same key pressed and released within one cycle window: release wins, no allocation.
- A note is never assigned to two voices. A re-press while assigned is impossible without a release in between.
- voice_div[v] is registered every cycle as note_div[voice_note[v]] when voice_en[v]=1, else 0.
  - Latency is 1 clk after a voice_note or note_div change.
  - An octave change reaches voice_div 1 clk after note_div updates.
- Widths: note index 4 bits. Values 12..15 are never generated; voice_div reads 0 for them.

Decomposition:
- Shared package (voice_pkg):
  - NUM_NOTES=12; note_idx_t (4-bit).
  - octave_t one-hot constants OCT_LOW/OCT_MID/OCT_HIGH.
  - CNT_W default.
- Sub-module sync_edge: 2-flop synchroniser plus rise/fall pulse outputs.
  - Parameterised width, instanced once for keys (12) and once for octave_btn (1).
- Top holds the octave FSM, pending mask, allocator and voice registers.

Test Plan:
- Reset then idle -> octave_sel=001, voice_en=0000, voice_div all 0. Assert nrst mid-allocation -> outputs cleared immediately, asynchronously.
- Three octave_btn pulses, each 5 clk wide -> octave_sel 010, 100, 001, each 3 clk after the rising edge. Force state 011 -> 001 next clk.
- Press key 9 (A), note_div[9]=22727 -> voice 0 note 9 en=1. voice_div[0]=22727 one clk later. Release -> voice_en[0]=0, voice_div[0]=0.
- Keys 0, 4, 7 pressed in the same cycle -> allocated on consecutive clks to voices 0, 1, 2 with notes 0, 4, 7.
- Hold keys 0..3, then press key 5 -> voice 0 stolen (note 5), steal_ptr=1. Press key 6 -> voice 1 stolen.
- With 4 voices full, release key 2 and press key 8 in the same cycle -> voice 2 receives note 8 with no steal; steal_ptr unchanged.
